// File: rtl/mips_mem_arbiter_pkg.sv
// rtl/mips_mem_arbiter_pkg.sv - shared types and helpers for the unified memory arbiter
package mips_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_ACCESS = 2'd1,
    ARB_DONE   = 2'd2
  } arb_state_e;

  typedef enum logic {
    ARB_OWN_CPU = 1'b0,
    ARB_OWN_LDR = 1'b1
  } arb_owner_e;

  // Bits needed to hold values 0..max_val inclusive (never narrower than 1).
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/mips_mem_arbiter_if.sv
// rtl/mips_mem_arbiter_if.sv - requester and memory-side signal bundle for the arbiter
interface mips_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack;
  logic              cpu_stall;

  logic              ldr_req;
  logic              ldr_we;
  logic [ADDR_W-1:0] ldr_addr;
  logic [DATA_W-1:0] ldr_wdata;
  logic [DATA_W-1:0] ldr_rdata;
  logic              ldr_ack;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Environment side: requesters and the memory macro.
  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_ack, cpu_stall,
    output ldr_req, ldr_we, ldr_addr, ldr_wdata,
    input  ldr_rdata, ldr_ack,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

  // Arbiter side.
  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_ack, cpu_stall,
    input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
    output ldr_rdata, ldr_ack,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );
endinterface

// File: rtl/mips_arb_lat_cnt.sv
// rtl/mips_arb_lat_cnt.sv - memory access cycle counter with terminal-count flag
module mips_arb_lat_cnt
  import mips_mem_arbiter_pkg::*;
#(
  parameter int MEM_LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc
);
  // Wide enough for MEM_LAT so the increment in the terminal cycle cannot wrap.
  localparam int CNT_W = cnt_w(MEM_LAT);
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(MEM_LAT - 1);

  logic [CNT_W-1:0] cnt_q;

  // Count access cycles; clear has priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (en) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/mips_mem_arbiter.sv
// rtl/mips_mem_arbiter.sv - shares one unified memory between the MIPS core and the boot loader
module mips_mem_arbiter
  import mips_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_LAT       = 2,
  parameter int LDR_BURST_MAX = 4
) (
  input logic              clk,
  input logic              rst_n,
  mips_mem_arbiter_if.slave bus
);
  localparam int RUN_W = cnt_w(LDR_BURST_MAX);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(LDR_BURST_MAX);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q, ldr_rdata_q;
  logic [RUN_W-1:0]  ldr_run_q;
  logic              grant, grant_ldr;
  logic              lat_tc;
  logic              cpu_ack, ldr_ack;

  mips_arb_lat_cnt #(.MEM_LAT(MEM_LAT)) u_lat_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_q != ARB_ACCESS),
    .en    (state_q == ARB_ACCESS),
    .tc    (lat_tc)
  );

  // Next state and arbitration: loader first, unless it has used up its burst while the core waits.
  always_comb begin
    state_d   = state_q;
    grant     = 1'b0;
    grant_ldr = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (bus.cpu_req || bus.ldr_req) begin
          grant     = 1'b1;
          grant_ldr = bus.ldr_req && !(bus.cpu_req && (ldr_run_q == RUN_MAX));
          state_d   = ARB_ACCESS;
        end
      end
      ARB_ACCESS: begin
        if (lat_tc) state_d = ARB_DONE;
      end
      ARB_DONE: begin
        state_d = ARB_IDLE;
      end
      default: begin
        state_d = ARB_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Capture the winner's transfer so requester changes during the access are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= ARB_OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (grant) begin
      owner_q <= grant_ldr ? ARB_OWN_LDR : ARB_OWN_CPU;
      we_q    <= grant_ldr ? bus.ldr_we    : bus.cpu_we;
      addr_q  <= grant_ldr ? bus.ldr_addr  : bus.cpu_addr;
      wdata_q <= grant_ldr ? bus.ldr_wdata : bus.cpu_wdata;
    end
  end

  // Loader burst length while the core is waiting; an idle core or a core grant restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ldr_run_q <= '0;
    end else if (state_q == ARB_IDLE) begin
      if (!bus.cpu_req) begin
        ldr_run_q <= '0;
      end else if (grant_ldr) begin
        if (ldr_run_q != RUN_MAX) ldr_run_q <= ldr_run_q + 1'b1;
      end else begin
        ldr_run_q <= '0;
      end
    end
  end

  // Read data capture in the last access cycle, only into the owner's register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_rdata_q <= '0;
      ldr_rdata_q <= '0;
    end else if ((state_q == ARB_ACCESS) && lat_tc && !we_q) begin
      if (owner_q == ARB_OWN_LDR) ldr_rdata_q <= bus.mem_rdata;
      else                        cpu_rdata_q <= bus.mem_rdata;
    end
  end

  assign cpu_ack = (state_q == ARB_DONE) && (owner_q == ARB_OWN_CPU);
  assign ldr_ack = (state_q == ARB_DONE) && (owner_q == ARB_OWN_LDR);

  assign bus.cpu_ack   = cpu_ack;
  assign bus.ldr_ack   = ldr_ack;
  assign bus.cpu_stall = bus.cpu_req & ~cpu_ack;
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.ldr_rdata = ldr_rdata_q;
  assign bus.mem_en    = (state_q == ARB_ACCESS);
  assign bus.mem_we    = (state_q == ARB_ACCESS) && we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule
